frogger_game_ctrl: RTL

FROGGER_GAME_CTRL -- requirements
Module: frogger_game_ctrl

---
 rtl/frogger_game_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frogger_game_ctrl
// Description : Frogger game-flow controller: lives, level, score, hit freeze
//               and respawn sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module frogger_game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int FREEZE_TICKS = 8,
    parameter int GOAL_ROW     = 0,
    parameter int MAX_LEVEL    = 7
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic [3:0] frog_y_i,
    input  logic       tick_i,
    output logic [2:0] state_o,
    output logic [1:0] lives_o,
    output logic [2:0] level_o,
    output logic [7:0] score_o,
    output logic       coll_clear_o,
    output logic       frog_respawn_o,
    output logic       game_active_o,
    output logic       game_over_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_HIT     = 3'd2,
        S_RESPAWN = 3'd3,
        S_LEVELUP = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam logic [1:0] C_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [3:0] C_FRZ_LAST   = 4'(FREEZE_TICKS - 1);
    localparam logic [3:0] C_GOAL_ROW   = 4'(GOAL_ROW);
    localparam logic [2:0] C_MAX_LEVEL  = 3'(MAX_LEVEL);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic [7:0] score_q, score_d;
    logic [3:0] freeze_cnt_q, freeze_cnt_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            lives_q      <= 2'd0;
            level_q      <= 3'd0;
            score_q      <= 8'd0;
            freeze_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            score_q      <= score_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        score_d      = score_q;
        freeze_cnt_d = freeze_cnt_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    state_d = S_RESPAWN;
                    lives_d = C_LIVES_INIT;
                    level_d = 3'd0;
                    score_d = 8'd0;
                end
            end
            S_RESPAWN: state_d = S_PLAY;
            S_PLAY: begin
                // A collision wins over reaching the goal row in the same cycle
                if (hit_i) begin
                    state_d      = S_HIT;
                    freeze_cnt_d = 4'd0;
                end else if (frog_y_i == C_GOAL_ROW) begin
                    state_d = S_LEVELUP;
                end
            end
            S_HIT: begin
                if (tick_i) begin
                    freeze_cnt_d = freeze_cnt_q + 4'd1;
                    if (freeze_cnt_q == C_FRZ_LAST) begin
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        state_d = (lives_q <= 2'd1) ? S_OVER : S_RESPAWN;
                    end
                end
            end
            S_LEVELUP: begin
                level_d = (level_q < C_MAX_LEVEL) ? level_q + 3'd1 : level_q;
                score_d = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                state_d = S_RESPAWN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o        = state_q;
    assign lives_o        = lives_q;
    assign level_o        = level_q;
    assign score_o        = score_q;
    assign coll_clear_o   = (state_q == S_RESPAWN);
    assign frog_respawn_o = (state_q == S_RESPAWN);
    assign game_active_o  = (state_q == S_PLAY);
    assign game_over_o    = (state_q == S_OVER);

endmodule
`default_nettype wire
